// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU load/store
// port and a DMA/debug port. The CPU has priority. The DMA port uses idle CPU
// slots. After MAX_WAIT lost conflicts, the DMA port gets a stall-protected
// burst window of up to BURST_MAX grants.
module dram_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int WW = $clog2(MAX_WAIT) + 1;
    localparam int BW = $clog2(BURST_MAX) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

    typedef enum logic {IDLE, DMA_OWN} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;

    // The CPU sees the RAM read port directly. Its data is only meaningful
    // while the CPU owns the port.
    assign cpu_rdata = ram_rdata;

    // Arbitration state: FSM, conflict counter and burst beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    // Next-state logic, grant logic and the RAM port mux.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        beat_nxt  = beat_cnt;
        cpu_stall = 1'b0;
        dma_gnt   = 1'b0;
        ram_we    = cpu_req & cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        case (state)
            IDLE: begin
                dma_gnt = dma_req & ~cpu_req;
                if (dma_gnt) begin
                    ram_we    = dma_we;
                    ram_addr  = dma_addr;
                    ram_wdata = dma_wdata;
                end
                if (cpu_req && dma_req) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = DMA_OWN;
                        wait_nxt  = '0;
                        beat_nxt  = '0;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    wait_nxt = '0;
                end
            end
            DMA_OWN: begin
                // The CPU is frozen for the whole window, even when it is idle.
                cpu_stall = 1'b1;
                dma_gnt   = dma_req;
                ram_we    = dma_req & dma_we;
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
                wait_nxt  = '0;
                if (!dma_req) begin
                    state_nxt = IDLE;
                end else begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == BEAT_LAST) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // DMA read return: registered one cycle after a read grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) dma_rdata <= ram_rdata;
        end
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
Shares the single-port data RAM between the CPU datapath's load/store port and a DMA/debug requester port. The CPU normally owns the RAM. The DMA port takes idle CPU slots immediately. After a bounded number of conflict cycles, the DMA port takes a stall-protected burst window. The block sits between the datapath and the data RAM and drives the CPU stall line.

Parameters:
DW, 32, data width of all data buses
AW, 32, address width of all address buses
MAX_WAIT, 4, conflict cycles a DMA request may lose before forcing a DMA burst window (>=1)
BURST_MAX, 8, maximum DMA grants per burst window (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU load/store access this cycle
cpu_we  in  1  CPU store
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  CPU load data; combinational copy of ram_rdata
cpu_stall  out  1  datapath must hold PC and suppress all state writes
dma_req  in  1  DMA access request; held with its address/data until granted
dma_we  in  1  DMA write
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_gnt  out  1  DMA access performed this cycle
dma_rdata  out  DW  DMA read data, registered
dma_rvalid  out  1  dma_rdata valid (one cycle after a read grant)
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rdata  in  DW  RAM read data; combinational read, writes take effect on clock edge

Behaviour:
- Registered state: FSM {IDLE, DMA_OWN}; wait_cnt (clog2(MAX_WAIT)+1 bits); beat_cnt (clog2(BURST_MAX)+1 bits); dma_rvalid; dma_rdata.
- Reset (sync, rst=1 at edge): state=IDLE, wait_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
- Outputs that follow combinationally after reset: cpu_stall=0; dma_gnt=dma_req&~cpu_req.
- A reset mid-burst aborts the burst. No rvalid is issued for a grant in the reset cycle.
- IDLE state:
  - cpu_stall=0.
  - dma_gnt = dma_req & ~cpu_req.
  - When dma_gnt=1, ram_* is driven from dma_*. Otherwise ram_* is driven from cpu_*, with ram_we = cpu_req & cpu_we.
  - Conflict (cpu_req & dma_req): the CPU is served. If wait_cnt == MAX_WAIT-1, go to DMA_OWN and clear wait_cnt and beat_cnt. Otherwise wait_cnt++.
  - Any cycle without a conflict clears wait_cnt.
- DMA_OWN state:
  - cpu_stall=1 regardless of cpu_req.
  - dma_gnt = dma_req. ram_* is driven from dma_*, with ram_we = dma_req & dma_we.
  - No RAM write is issued when dma_req=0.
  - Each grant increments beat_cnt.
  - Return to IDLE after the grant with beat_cnt == BURST_MAX-1, or on any cycle with dma_req=0. No grant is given on a dma_req=0 cycle.
  - On return, wait_cnt=0, so a continuing DMA request must wait MAX_WAIT conflict cycles again. This bounds CPU starvation.
- Read data: every cycle, dma_rvalid <= dma_gnt & ~dma_we. When that term is 1, dma_rdata <= ram_rdata; otherwise dma_rdata holds. Latency is 1 cycle after the grant.
- Writes: a write lands at the edge ending its grant cycle. A DMA read granted in the following cycle returns the new data.
- Worst-case DMA wait is MAX_WAIT cycles. Worst-case CPU stall is BURST_MAX cycles per window.
- cpu_rdata is always ram_rdata. It is only meaningful when the CPU owns the port.

Test Plan:
- Reset: assert rst for 2 cycles during an active DMA_OWN burst -> next cycle state=IDLE, cpu_stall=0, dma_rvalid=0, dma_rdata=0.
- Idle steal: cpu_req=0, dma_req=1, dma_we=1, addr 0x10, data 0xDEADBEEF -> dma_gnt=1 same cycle, ram_we=1. Next cycle a DMA read of 0x10 gives dma_rvalid=1 with 0xDEADBEEF one cycle later.
- Forced window: cpu_req and dma_req held at 1, MAX_WAIT=4 -> CPU served for 4 cycles with cpu_stall=0, then cpu_stall=1 and dma_gnt=1 for exactly 8 cycles, then back to IDLE with cpu_stall=0.
- Early release: in DMA_OWN after 3 grants, drop dma_req -> that cycle dma_gnt=0 and ram_we=0, next cycle IDLE, and the CPU store at 0x20 with 0x12345678 is written.
- Read pipeline: DMA back-to-back reads of addresses 0,4,8 containing 1,2,3 in a DMA_OWN window -> dma_rvalid high for 3 consecutive cycles, starting 1 cycle after the first grant, with dma_rdata 1,2,3.
- No conflict resets wait: 3 conflict cycles, then 1 cycle with cpu_req=0 (DMA granted), then conflicts resume -> the DMA_OWN window opens only after 4 further conflict cycles.
